// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Shares the single-port data memory between the MEM stage (CPU)
//            and a loader/debug master, with starvation guard and burst lock.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    // CPU (MEM stage) port
    input  logic        cpu_req,
    input  logic        cpu_halt,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    // Loader / debug port
    input  logic        ldr_req,
    input  logic        ldr_lock,
    input  logic        ldr_we,
    input  logic [31:0] ldr_addr,
    input  logic [1:0]  ldr_size,
    input  logic [31:0] ldr_wdata,
    output logic        ldr_gnt,
    output logic        ldr_err,
    output logic [31:0] ldr_rdata,
    output logic        ldr_rvalid,
    // DataMem port
    output logic [31:0] dmem_addr,
    output logic [1:0]  dmem_size,
    output logic [31:0] dmem_wdata,
    output logic        dmem_wen_n,
    input  logic [31:0] dmem_rdata
);

    localparam logic [1:0] c_size_hword = 2'b01;
    localparam logic [1:0] c_size_word  = 2'b10;

    localparam logic [0:0] S_CPU  = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    localparam logic [CNT_W-1:0] c_starve_limit = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] c_cnt_max      = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [31:0]      r_ldr_rdata;
    logic             r_ldr_rvalid;

    logic w_ldr_mis;
    logic w_force;
    logic w_cpu_own;
    logic w_ldr_own;
    logic w_cpu_stall;
    logic w_ldr_gnt;
    logic w_ldr_err;

    assign w_ldr_mis = ((ldr_size == c_size_hword) && ldr_addr[0]) ||
                       ((ldr_size == c_size_word)  && (ldr_addr[1:0] != 2'b00));

    assign w_force = ldr_req && (r_starve_cnt >= c_starve_limit);

    // Ownership: a locked burst shuts the CPU out even between loader beats.
    always_comb begin
        w_cpu_own   = 1'b0;
        w_ldr_own   = 1'b0;
        w_cpu_stall = 1'b0;
        if (r_state == S_LOCK) begin
            w_ldr_own   = ldr_req;
            w_cpu_stall = cpu_req;
        end else if (w_force) begin
            w_ldr_own   = 1'b1;
            w_cpu_stall = cpu_req;
        end else if (cpu_req) begin
            w_cpu_own   = 1'b1;
        end else if (ldr_req) begin
            w_ldr_own   = 1'b1;
        end
    end

    assign w_ldr_gnt = w_ldr_own && !w_ldr_mis;
    assign w_ldr_err = w_ldr_own &&  w_ldr_mis;

    always_comb begin
        dmem_addr  = 32'h0;
        dmem_size  = 2'b00;
        dmem_wdata = 32'h0;
        dmem_wen_n = 1'b1;
        if (w_cpu_own) begin
            dmem_addr  = cpu_addr;
            dmem_size  = cpu_size;
            dmem_wdata = cpu_wdata;
            dmem_wen_n = ~cpu_we | cpu_halt;
        end else if (w_ldr_own) begin
            // A rejected (misaligned) loader access must leave memory untouched.
            dmem_addr  = ldr_addr;
            dmem_size  = ldr_size;
            dmem_wdata = ldr_wdata;
            dmem_wen_n = ~ldr_we | w_ldr_mis;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_CPU;
            r_starve_cnt <= '0;
            r_ldr_rdata  <= 32'h0;
            r_ldr_rvalid <= 1'b0;
        end else begin
            r_ldr_rvalid <= w_ldr_gnt && !ldr_we;
            if (w_ldr_gnt && !ldr_we) begin
                r_ldr_rdata <= dmem_rdata;
            end

            if (ldr_req && !w_ldr_gnt && !w_ldr_err) begin
                if (r_starve_cnt != c_cnt_max) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else begin
                r_starve_cnt <= '0;
            end

            case (r_state)
                S_CPU: begin
                    if (w_ldr_gnt && ldr_lock) begin
                        r_state <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (w_ldr_err || (w_ldr_gnt && !ldr_lock) ||
                        (!ldr_req && !ldr_lock)) begin
                        r_state <= S_CPU;
                    end
                end
                default: r_state <= S_CPU;
            endcase
        end
    end

    assign cpu_stall  = w_cpu_stall;
    assign cpu_rdata  = dmem_rdata;
    assign ldr_gnt    = w_ldr_gnt;
    assign ldr_err    = w_ldr_err;
    assign ldr_rdata  = r_ldr_rdata;
    assign ldr_rvalid = r_ldr_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Brief    : Scoreboard bench for dmem_port_arbiter with a behavioural DataMem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam logic [1:0]  c_word  = 2'b10;
    localparam logic [1:0]  c_hword = 2'b01;
    localparam logic [31:0] c_beef  = 32'hDEAD_BEEF;
    localparam logic [31:0] c_d0    = 32'hA0A0_A0A0;
    localparam logic [31:0] c_d1    = 32'hB1B1_B1B1;
    localparam logic [31:0] c_d2    = 32'hC2C2_C2C2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_halt, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        ldr_req, ldr_lock, ldr_we;
    logic [31:0] ldr_addr, ldr_wdata;
    logic [1:0]  ldr_size;
    logic        ldr_gnt, ldr_err, ldr_rvalid;
    logic [31:0] ldr_rdata;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0]  dmem_size;
    logic        dmem_wen_n;

    logic [31:0] mem [0:63];

    typedef struct {
        logic        stall, gnt, err, wen_n, rv, chk;
        logic [31:0] rd;
        int          tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    int          total = 0;
    int          bad   = 0;
    int          step_no = 0;

    dmem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_halt(cpu_halt), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_size(cpu_size), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_lock(ldr_lock), .ldr_we(ldr_we),
        .ldr_addr(ldr_addr), .ldr_size(ldr_size), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_err(ldr_err), .ldr_rdata(ldr_rdata),
        .ldr_rvalid(ldr_rvalid),
        .dmem_addr(dmem_addr), .dmem_size(dmem_size), .dmem_wdata(dmem_wdata),
        .dmem_wen_n(dmem_wen_n), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    // Word-wide memory model: combinational read, write at the clock edge.
    assign dmem_rdata = mem[dmem_addr[7:2]];
    always @(posedge clk) begin
        if (!dmem_wen_n) mem[dmem_addr[7:2]] <= dmem_wdata;
    end

    task automatic check(input string name, input int tag,
                         input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, tag, act, want);
        end
    endtask

    // Monitor: per-cycle expectations plus a read-data scoreboard keyed on rvalid.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cpu_stall",  e.tag, {31'h0, cpu_stall},  {31'h0, e.stall});
            check("ldr_gnt",    e.tag, {31'h0, ldr_gnt},    {31'h0, e.gnt});
            check("ldr_err",    e.tag, {31'h0, ldr_err},    {31'h0, e.err});
            check("dmem_wen_n", e.tag, {31'h0, dmem_wen_n}, {31'h0, e.wen_n});
            check("ldr_rvalid", e.tag, {31'h0, ldr_rvalid}, {31'h0, e.rv});
            if (e.chk) check("cpu_rdata", e.tag, cpu_rdata, e.rd);
        end
        if (ldr_rvalid) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ldr_rdata unexpected rvalid: got %h expected none", ldr_rdata);
            end else begin
                check("ldr_rdata", step_no, ldr_rdata, rd_q.pop_front());
            end
        end
    end

    task automatic set_cpu(input logic req, input logic we, input logic halt,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req = req; cpu_we = we; cpu_halt = halt;
        cpu_addr = addr; cpu_size = c_word; cpu_wdata = wdata;
    endtask

    task automatic set_ldr(input logic req, input logic lock, input logic we,
                           input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata);
        ldr_req = req; ldr_lock = lock; ldr_we = we;
        ldr_addr = addr; ldr_size = size; ldr_wdata = wdata;
    endtask

    task automatic step(input logic s, input logic g, input logic e, input logic w,
                        input logic rv, input logic ck, input logic [31:0] rd);
        exp_t x;
        x.stall = s; x.gnt = g; x.err = e; x.wen_n = w;
        x.rv = rv; x.chk = ck; x.rd = rd; x.tag = step_no;
        step_no++;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst = 1'b1;
        set_cpu(0, 0, 0, 32'h0, 32'h0);
        set_ldr(0, 0, 0, 32'h0, c_word, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 0, 1, 0, 0, 32'h0);           // reset state
        rst = 1'b0;

        // CPU store then load
        set_cpu(1, 1, 0, 32'h10, c_beef);
        step(0, 0, 0, 0, 0, 0, 32'h0);
        set_cpu(1, 0, 0, 32'h10, 32'h0);
        step(0, 0, 0, 1, 0, 1, c_beef);

        // Loader-only read
        set_cpu(0, 0, 0, 32'h0, 32'h0);
        set_ldr(1, 0, 0, 32'h10, c_word, 32'h0);
        rd_q.push_back(c_beef);
        step(0, 1, 0, 1, 0, 1, c_beef);
        set_ldr(0, 0, 0, 32'h0, c_word, 32'h0);
        step(0, 0, 0, 1, 1, 0, 32'h0);
        step(0, 0, 0, 1, 0, 0, 32'h0);

        // Contention: loader forced through every fifth cycle
        set_cpu(1, 0, 0, 32'h10, 32'h0);
        set_ldr(1, 0, 0, 32'h10, c_word, 32'h0);
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) rd_q.push_back(c_beef);
            step((k % 5 == 4), (k % 5 == 4), 0, 1, (k == 5), 1, c_beef);
        end
        set_cpu(0, 0, 0, 32'h0, 32'h0);
        set_ldr(0, 0, 0, 32'h0, c_word, 32'h0);
        step(0, 0, 0, 1, 1, 0, 32'h0);

        // Locked write burst, entered via starvation force
        set_cpu(1, 0, 0, 32'h30, 32'h0);
        set_ldr(1, 1, 1, 32'h20, c_word, c_d0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0, 1, 32'h0);
        step(1, 1, 0, 0, 0, 0, 32'h0);
        set_ldr(1, 1, 1, 32'h24, c_word, c_d1);
        step(1, 1, 0, 0, 0, 0, 32'h0);
        set_ldr(1, 0, 1, 32'h28, c_word, c_d2);
        step(1, 1, 0, 0, 0, 0, 32'h0);
        set_ldr(0, 0, 0, 32'h0, c_word, 32'h0);
        set_cpu(1, 0, 0, 32'h20, 32'h0);
        step(0, 0, 0, 1, 0, 1, c_d0);
        set_cpu(1, 0, 0, 32'h24, 32'h0);
        step(0, 0, 0, 1, 0, 1, c_d1);
        set_cpu(1, 0, 0, 32'h28, 32'h0);
        step(0, 0, 0, 1, 0, 1, c_d2);

        // Misaligned loader requests, then confirm counter restarted from zero
        set_cpu(0, 0, 0, 32'h0, 32'h0);
        set_ldr(1, 0, 1, 32'h22, c_word, 32'hFFFF_FFFF);
        step(0, 0, 1, 1, 0, 0, 32'h0);
        set_ldr(1, 0, 0, 32'h21, c_hword, 32'h0);
        step(0, 0, 1, 1, 0, 0, 32'h0);
        set_cpu(1, 0, 0, 32'h24, 32'h0);
        set_ldr(1, 0, 0, 32'h20, c_word, 32'h0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0, 1, c_d1);
        rd_q.push_back(c_d0);
        step(1, 1, 0, 1, 0, 1, c_d0);
        set_cpu(0, 0, 0, 32'h0, 32'h0);
        set_ldr(0, 0, 0, 32'h0, c_word, 32'h0);
        step(0, 0, 0, 1, 1, 0, 32'h0);

        // Halted CPU store must not write
        set_cpu(1, 1, 1, 32'h10, 32'h1234_5678);
        step(0, 0, 0, 1, 0, 0, 32'h0);
        set_cpu(1, 0, 0, 32'h10, 32'h0);
        step(0, 0, 0, 1, 0, 1, c_beef);

        // Enter lock, then reset mid-burst
        set_cpu(0, 0, 0, 32'h0, 32'h0);
        set_ldr(1, 1, 0, 32'h24, c_word, 32'h0);
        rd_q.push_back(c_d1);
        step(0, 1, 0, 1, 0, 1, c_d1);
        set_cpu(1, 0, 0, 32'h10, 32'h0);
        set_ldr(1, 1, 0, 32'h28, c_word, 32'h0);
        step(1, 1, 0, 1, 1, 0, 32'h0);
        set_ldr(0, 1, 0, 32'h0, c_word, 32'h0);
        #1;
        check("lock_stall_pre_rst", step_no, {31'h0, cpu_stall}, 32'h1);
        check("rvalid_pre_rst", step_no, {31'h0, ldr_rvalid}, 32'h1);
        rst = 1'b1;
        #1;
        check("stall_in_rst", step_no, {31'h0, cpu_stall}, 32'h0);
        check("rvalid_in_rst", step_no, {31'h0, ldr_rvalid}, 32'h0);
        check("gnt_in_rst", step_no, {31'h0, ldr_gnt}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 1, 0, 1, c_beef);
        set_cpu(0, 0, 0, 32'h0, 32'h0);
        set_ldr(0, 0, 0, 32'h0, c_word, 32'h0);
        step(0, 0, 0, 1, 0, 0, 32'h0);

        @(negedge clk);
        #1;
        check("exp_q_drained", step_no, exp_q.size(), 0);
        check("rd_q_drained", step_no, rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
